// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control unit.
// Moore FSM that sequences fetch / decode / execute / memory / writeback for
// a datapath with one unified memory port, and counts retired instructions.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN -- when defined, unsupported
// opcodes park the FSM in a TRAP state and raise 'illegal' until reset.
// Without it, unsupported opcodes retire as NOPs and 'illegal' is tied low.

module rv_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             adr_src,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             reg_write,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    // Opcodes handled by this controller
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // ALU operation classes (internal)
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] instret_reg;
    logic [1:0]       alu_op;

    // Next-state selection; memory states hold until the access completes
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYP:      state_next = S_EXECR;
                    OP_ITYP:      state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_next = S_TRAP;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            // op[5] separates store (1) from load (0) among memory opcodes
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_next = S_TRAP;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    // State register and retire counter; an instruction retires on any
    // return to FETCH from another state (TRAP never returns, so it holds)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg != S_FETCH && state_next == S_FETCH)
                instret_reg <= instret_reg + 1'b1;
        end
    end

    assign instret = instret_reg;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_reg == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    // Moore control outputs; reset forces every enable and select low
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write   = 1'b0;
        alu_op      = ALUOP_ADD;
        alu_control = 3'b000;

        // Immediate format follows the opcode regardless of state
        case (op)
            OP_LW, OP_ITYP: imm_src = 2'b00;
            OP_SW:          imm_src = 2'b01;
            OP_BEQ:         imm_src = 2'b10;
            OP_JAL:         imm_src = 2'b11;
            default:        imm_src = 2'b00;
        endcase

        case (state_reg)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNC;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                pc_write  = zero;
            end
            default: begin
            end
        endcase

        // ALU function; only R-type (op[5]=1) with funct7b5 subtracts
        case (alu_op)
            ALUOP_ADD: alu_control = 3'b000;
            ALUOP_SUB: alu_control = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
        endcase

        if (reset) begin
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            imm_src     = 2'b00;
            alu_control = 3'b000;
            reg_write   = 1'b0;
        end
    end

endmodule
